// File: rtl/seqpu_cpu.sv
// seqpu_cpu: 16-bit multi-cycle accumulator CPU (A, B, SP, PC, carry).
// Ports: clk, rst_n, address/data_out/data_in, wren_n/oen_n to async SRAM.
module seqpu_cpu (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] address,
  output logic [15:0] data_out,
  input  logic [15:0] data_in,
  output logic        wren_n,
  output logic        oen_n
);

  localparam logic [2:0] FETCH   = 3'd0;
  localparam logic [2:0] EXECUTE = 3'd1;
  localparam logic [2:0] ALU     = 3'd2;
  localparam logic [2:0] LOAD    = 3'd3;

  logic [2:0]  state;
  logic [3:0]  counter;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] sp;
  logic [15:0] pc;
  logic [15:0] op;
  logic        carry;

  logic [15:0] x;
  logic [16:0] sum;
  logic [15:0] res;
  logic        c;
  logic [15:0] a_shift;
  logic [15:0] pc_inc;

  assign x      = op[15] ? a : sp;
  assign pc_inc = pc + 16'd1;

  always_comb begin
    sum = 17'd0;
    res = 16'd0;
    c   = 1'b0;
    unique case (op[11:9])
      3'b000: begin
        sum = {1'b0, x} + {1'b0, b};
        res = sum[15:0];
        c   = sum[16];
      end
      3'b001: begin res = x - b; c = (x >= b); end
      3'b010: begin res = x | b; c = |x; end
      3'b011: begin res = x & b; c = &x; end
      3'b100: begin res = x ^ b; c = ^x; end
      3'b101: begin res = x; c = (x == b); end
      3'b110: begin res = x; c = (x > b); end
      default: begin res = b; c = 1'b0; end
    endcase
  end

  // Funnel shift of {res,A}; A >> 16 yields 0 so r=0 gives res.
  assign a_shift = (res << op[3:0]) |
                   (a >> (5'd16 - {1'b0, op[3:0]}));

  // Bus outputs; reset forces both strobes inactive.
  always_comb begin
    address  = sp;
    data_out = a;
    wren_n   = 1'b1;
    oen_n    = 1'b1;
    if (rst_n) begin
      case (state)
        FETCH: begin
          address = pc;
          oen_n   = 1'b0;
        end
        EXECUTE: begin
          if (op[15:13] == 3'b010) wren_n = 1'b0;
        end
        LOAD: oen_n = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      counter <= 4'd0;
      a       <= 16'd0;
      b       <= 16'd0;
      sp      <= 16'd0;
      pc      <= 16'd0;
      op      <= 16'd0;
      carry   <= 1'b0;
    end else begin
      counter <= 4'd0;
      case (state)
        FETCH: begin
          op <= data_in;
          // counter is a wait-state hook; it is always 0 today
          if (counter == 4'd0) state <= EXECUTE;
        end
        EXECUTE: begin
          unique case (1'b1)
            op[15:14] == 2'b00: b <= {2'b00, op[13:0]};
            op[15:14] == 2'b11: b <= {{8{op[8]}}, op[7:0]};
            default: ;
          endcase
          state <= ALU;
        end
        ALU: begin
          if (!op[15]) begin
            pc    <= pc_inc;
            state <= (op[15:13] == 3'b011) ? LOAD : FETCH;
          end else begin
            state <= FETCH;
            case (op[13:12])
              2'b00: begin
                a     <= res;
                carry <= c;
                pc    <= pc_inc;
              end
              2'b01: begin
                sp <= res;
                pc <= pc_inc;
              end
              2'b10: pc <= carry ? res : pc_inc;
              default: begin
                a  <= a_shift;
                pc <= pc_inc;
              end
            endcase
          end
        end
        LOAD: begin
          b     <= data_in;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_seqpu_cpu.sv
// tb_seqpu_cpu: directed program for seqpu_cpu against a behavioural SRAM.
// Checks bus strobes, register results, store/load and conditional jump.
module tb_seqpu_cpu;

  logic        clk;
  logic        rst_n;
  logic [15:0] address;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        wren_n;
  logic        oen_n;

  logic [15:0] mem [0:65535];
  int          checks;
  int          errors;
  logic        mon_on;

  seqpu_cpu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .data_out (data_out),
    .data_in  (data_in),
    .wren_n   (wren_n),
    .oen_n    (oen_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_in = mem[address];

  always @(posedge clk)
    if (!wren_n) mem[address] <= data_out;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // strobes must never be active together
  always @(negedge clk)
    if (mon_on) check("strobe_excl", {15'd0, wren_n | oen_n}, 16'd1);

  initial begin
    checks = 0;
    errors = 0;
    mon_on = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
    mem[0]      = 16'h1234; // ld lit B
    mem[1]      = 16'hCFFF; // B=FFFF, A=B
    mem[2]      = 16'h0001; // B=1
    mem[3]      = 16'h8000; // A=A+B
    mem[4]      = 16'h0100; // B=0100
    mem[5]      = 16'h9E00; // SP=B
    mem[6]      = 16'hCFFF; // A=FFFF, carry 0
    mem[7]      = 16'h0BEE; // B=0BEE
    mem[8]      = 16'hBE04; // A={B,A}<<4 upper
    mem[9]      = 16'h6000; // ld [SP],B
    mem[10]     = 16'h4000; // st A,[SP]
    mem[11]     = 16'h0040; // B=0040
    mem[12]     = 16'h8E00; // A=B, carry 0
    mem[13]     = 16'hE400; // jc A|0, not taken
    mem[14]     = 16'hC200; // A=A-0, carry 1
    mem[15]     = 16'hE400; // jc A|0, taken
    mem[16'h40] = 16'h8E00;
    mem[16'h100] = 16'h5A5A;

    rst_n = 1'b0;
    step(2);
    check("rst_wren", {15'd0, wren_n}, 16'd1);
    check("rst_oen", {15'd0, oen_n}, 16'd1);
    mon_on = 1'b1;
    rst_n = 1'b1;
    #1;
    check("rel_state", {13'd0, dut.state}, 16'd0);
    check("rel_addr", address, 16'h0000);
    check("rel_oen", {15'd0, oen_n}, 16'd0);
    check("rel_wren", {15'd0, wren_n}, 16'd1);

    step(1);
    check("exec_state", {13'd0, dut.state}, 16'd1);
    step(1);
    check("ldlit_b", dut.b, 16'h1234);
    check("ldlit_alu", {13'd0, dut.state}, 16'd2);
    step(1);
    check("ldlit_pc", dut.pc, 16'd1);
    check("ldlit_a", dut.a, 16'd0);
    check("ldlit_sp", dut.sp, 16'd0);
    check("ldlit_fetch", {13'd0, dut.state}, 16'd0);

    step(3);
    check("movlit_a", dut.a, 16'hFFFF);
    step(6);
    check("add_a", dut.a, 16'h0000);
    check("add_c", {15'd0, dut.carry}, 16'd1);
    check("add_pc", dut.pc, 16'd4);

    step(6);
    check("sp_set", dut.sp, 16'h0100);
    step(3);
    check("a_ffff", dut.a, 16'hFFFF);
    check("c_clr", {15'd0, dut.carry}, 16'd0);
    step(6);
    check("shift_a", dut.a, 16'hBEEF);

    // ld [SP],B
    step(1);
    check("ld_exec_oen", {15'd0, oen_n}, 16'd1);
    check("ld_exec_wren", {15'd0, wren_n}, 16'd1);
    step(2);
    check("ld_state", {13'd0, dut.state}, 16'd3);
    check("ld_addr", address, 16'h0100);
    check("ld_oen", {15'd0, oen_n}, 16'd0);
    step(1);
    check("ld_b", dut.b, 16'h5A5A);
    check("ld_pc", dut.pc, 16'd10);

    // st A,[SP]
    step(1);
    check("st_addr", address, 16'h0100);
    check("st_data", data_out, 16'hBEEF);
    check("st_wren", {15'd0, wren_n}, 16'd0);
    check("st_oen", {15'd0, oen_n}, 16'd1);
    step(2);
    check("st_mem", mem[16'h100], 16'hBEEF);
    check("st_pc", dut.pc, 16'd11);

    step(6);
    check("a_40", dut.a, 16'h0040);
    step(3);
    check("jnc_pc", dut.pc, 16'd14);
    step(3);
    check("sub_c", {15'd0, dut.carry}, 16'd1);
    check("sub_a", dut.a, 16'h0040);
    step(3);
    check("jc_pc", dut.pc, 16'h0040);
    check("jc_addr", address, 16'h0040);

    // abort mid-instruction
    step(1);
    rst_n = 1'b0;
    #1;
    check("abort_wren", {15'd0, wren_n}, 16'd1);
    check("abort_oen", {15'd0, oen_n}, 16'd1);
    check("abort_pc", dut.pc, 16'd0);
    check("abort_state", {13'd0, dut.state}, 16'd0);
    step(1);
    rst_n = 1'b1;
    #1;
    check("resume_addr", address, 16'h0000);
    check("resume_oen", {15'd0, oen_n}, 16'd0);
    step(1);
    check("resume_op", dut.op, 16'h1234);

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
